// File: rtl/commit_scheduler_pkg.sv
// Shared types for the commit scheduler: requester indices, output-register
// state and the reorder-buffer entry layout.
package commit_scheduler_pkg;

    localparam int ITU   = 0;
    localparam int LSU   = 1;
    localparam int CSR   = 2;
    localparam int TAG_W = 6;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        exc;
    } rob_entry_t;

endpackage

// File: rtl/commit_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (modulo NUM_REQ) wins,
// unless any requester is flagged in prio_i, in which case the lowest such wins.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    input  logic [NUM_REQ-1:0] prio_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PW-1:0]      grant_idx_o
);

    logic [NUM_REQ-1:0] w_prio_req;
    logic [PW-1:0]      w_cand;
    logic               w_any;

    assign w_prio_req = prio_i & req_i;

    // Scans run high-to-low so the last hit is the first in priority order.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        w_cand      = '0;
        w_any       = 1'b0;
        if (|w_prio_req) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_prio_req[i]) begin
                    grant_idx_o = PW'(i);
                    w_any       = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                w_cand = PW'((int'(ptr_i) + k) % NUM_REQ);
                if (req_i[w_cand]) begin
                    grant_idx_o = w_cand;
                    w_any       = 1'b1;
                end
            end
        end
        if (w_any) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/commit_scheduler.sv
// Schedules ITU/LSU/CSR commit buffers onto the single ROB write port through a
// one-deep output register. Optional starvation guard: STARVATION_GUARD_EN.
module commit_scheduler
    import commit_scheduler_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           stall_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag_i,
    input  rob_entry_t [NUM_REQ-1:0]       req_entry_i,
    output logic                           rob_write_o,
    output logic [TAG_W-1:0]               rob_tag_o,
    output rob_entry_t                     rob_entry_o,
    output logic [1:0]                     grant_id_o,
    output logic                           starved_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a buffer's entry transfers on the edge where req_valid_i[i] &
    // req_ready_o[i]; ready is only offered when the output register can load.
    out_state_e          r_state;
    logic [PW-1:0]       r_ptr;
    logic [TAG_W-1:0]    r_tag;
    rob_entry_t          r_entry;
    logic [1:0]          r_gid;

    logic                w_load_en;
    logic                w_arb_en;
    logic [NUM_REQ-1:0]  w_req;
    logic [NUM_REQ-1:0]  w_prio;
    logic [NUM_REQ-1:0]  w_grant;
    logic [PW-1:0]       w_gidx;
    logic                w_fire;

    assign w_load_en = (r_state == EMPTY) | ~stall_i;
    assign w_arb_en  = w_load_en & ~flush_i & ~rst_i;
    assign w_req     = req_valid_i & {NUM_REQ{w_arb_en}};
    assign w_fire    = |w_grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (w_req),
        .ptr_i       (r_ptr),
        .prio_i      (w_prio),
        .grant_o     (w_grant),
        .grant_idx_o (w_gidx)
    );

    assign req_ready_o = w_grant;
    assign rob_write_o = (r_state == FULL);
    assign rob_tag_o   = r_tag;
    assign rob_entry_o = r_entry;
    assign grant_id_o  = r_gid;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_tag   <= '0;
            r_entry <= '0;
            r_gid   <= '0;
        end else if (w_fire) begin
            r_state <= FULL;
            r_tag   <= req_tag_i[w_gidx];
            r_entry <= req_entry_i[w_gidx];
            r_gid   <= 2'(w_gidx);
            r_ptr   <= (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
        end else if (!stall_i) begin
            r_state <= EMPTY;
        end
    end

`ifdef STARVATION_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [NUM_REQ-1:0][CW-1:0] r_wait;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wait <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid_i[i] || w_grant[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != CW'(STARVE_LIMIT)) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_prio = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_prio[i] = (r_wait[i] == CW'(STARVE_LIMIT));
        end
    end

    assign starved_o = |w_prio;
`else
    assign w_prio    = '0;
    // The limit has no effect without the guard; this is constant 0.
    assign starved_o = (STARVE_LIMIT < 0);
`endif

endmodule

// File: tb/tb_commit_scheduler.sv
// Self-checking bench for commit_scheduler: randomized and directed stimulus
// against a behavioural model, with a scoreboard monitor on the outputs.
module tb_commit_scheduler;
  import commit_scheduler_pkg::*;

  localparam int LIMIT = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             stall;
  logic [2:0]       valid;
  logic [2:0]       req_ready;
  logic [2:0][5:0]  tags;
  rob_entry_t [2:0] ents;
  logic             rob_write;
  logic [5:0]       rob_tag;
  rob_entry_t       rob_entry;
  logic [1:0]       grant_id;
  logic             starved;

  commit_scheduler #(.NUM_REQ(3), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .stall_i     (stall),
    .req_valid_i (valid),
    .req_ready_o (req_ready),
    .req_tag_i   (tags),
    .req_entry_i (ents),
    .rob_write_o (rob_write),
    .rob_tag_o   (rob_tag),
    .rob_entry_o (rob_entry),
    .grant_id_o  (grant_id),
    .starved_o   (starved)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  logic [45:0] exp_q[$];
  logic [3:0]  rdy_q[$];

  // Reference model state: output register contents, pointer, wait counts.
  int         m_full;
  int         m_ptr;
  int         m_cnt[3];
  logic [5:0] m_tag;
  rob_entry_t m_ent;
  int         m_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot(input int g);
    return (g >= 0) ? 3'(1 << g) : 3'b000;
  endfunction

  // Winner by the scheduling rules: nothing when flushing or held under stall,
  // else a starved requester (guard builds), else the rotation from ptr.
  function automatic int model_pick(input logic [2:0] v, input logic st, input logic fl);
    if (fl || (m_full != 0 && st)) return -1;
`ifdef STARVATION_GUARD_EN
    for (int i = 0; i < 3; i++)
      if (v[i] && m_cnt[i] == LIMIT) return i;
`endif
    for (int k = 0; k < 3; k++)
      if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  task automatic drive(input logic [2:0] v, input logic st, input logic fl,
                       input int want, input int ftag);
    int   g;
    logic sv;
    @(posedge clk);
    #2;
    rst   = 1'b0;
    flush = fl;
    stall = st;
    valid = v;
    for (int i = 0; i < 3; i++) begin
      tags[i] = (ftag >= 0) ? 6'(ftag) : 6'($urandom_range(0, 63));
      ents[i] = '{result: $urandom, rd: 5'($urandom_range(0, 31)), exc: 1'($urandom_range(0, 1))};
    end
    g  = model_pick(v, st, fl);
    sv = 1'b0;
`ifdef STARVATION_GUARD_EN
    for (int i = 0; i < 3; i++)
      if (m_cnt[i] == LIMIT) sv = 1'b1;
`endif
    rdy_q.push_back({sv, onehot(g)});
    if (fl) begin
      m_full = 0;
      m_ptr  = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      if (g >= 0) begin
        m_full = 1;
        m_tag  = tags[g];
        m_ent  = ents[g];
        m_id   = g;
        m_ptr  = (g + 1) % 3;
      end else if (!st) begin
        m_full = 0;
      end
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || i == g) m_cnt[i] = 0;
        else if (m_cnt[i] < LIMIT) m_cnt[i]++;
      end
    end
    if (m_full != 0) exp_q.push_back({m_tag, m_ent, 2'(m_id)});
    mon_en = 1'b1;
    if (want != -2) begin
      #1;
      chk("dir_grant", 64'(req_ready), 64'(onehot(want)));
    end
  endtask

  // Monitor: ready/starved every cycle, ROB write contents whenever presented.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rdy_q.size() == 0) begin
        chk("ready_underflow", 64'd1, 64'd0);
      end else begin
        chk("ready_starved", 64'({starved, req_ready}), 64'(rdy_q.pop_front()));
      end
      if (rob_write) begin
        if (exp_q.size() == 0) chk("rob_unexpected_write", 64'd1, 64'd0);
        else chk("rob_out", 64'({rob_tag, rob_entry, grant_id}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    m_full = 0;
    m_ptr  = 0;
    m_tag  = '0;
    m_ent  = '0;
    m_id   = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    rst   = 1'b1;
    flush = 1'b0;
    stall = 1'b0;
    valid = 3'b111;
    tags  = '0;
    ents  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write", 64'(rob_write), 64'd0);
    chk("rst_tag",   64'(rob_tag),   64'd0);
    chk("rst_entry", 64'(rob_entry), 64'd0);
    chk("rst_gid",   64'(grant_id),  64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_starv", 64'(starved),   64'd0);

    // Rotation with all requesting, then ptr=1 with 101, then wrap from ptr=2.
    drive(3'b111, 0, 0, ITU, -1);
    drive(3'b111, 0, 0, LSU, -1);
    drive(3'b111, 0, 0, CSR, -1);
    drive(3'b001, 0, 0, ITU, -1);
    drive(3'b101, 0, 0, CSR, -1);
    drive(3'b010, 0, 0, LSU, -1);
    drive(3'b001, 0, 0, ITU, -1);
    drive(3'b110, 0, 0, LSU, -1);

    // Hold tag 5 under backpressure, LSU waits, then is granted on release.
    drive(3'b100, 0, 0, CSR, 5);
    repeat (4) drive(3'b010, 1, 0, -1, -1);
    drive(3'b010, 0, 0, LSU, -1);
    drive(3'b000, 0, 0, -1, -1);

    // Flush while full and stalled; ptr restarts at ITU.
    drive(3'b001, 0, 0, ITU, -1);
    drive(3'b111, 1, 1, -1, -1);
    drive(3'b111, 0, 0, ITU, -1);
    drive(3'b111, 0, 0, LSU, -1);

    // LSU kept waiting behind a stalled entry until its counter saturates.
    drive(3'b100, 0, 0, CSR, -1);
    repeat (8) drive(3'b010, 1, 0, -1, -1);
`ifdef STARVATION_GUARD_EN
    drive(3'b011, 0, 0, LSU, -1);
    chk("starved_flag", 64'(starved), 64'd1);
`else
    drive(3'b011, 0, 0, ITU, -1);
    chk("starved_flag", 64'(starved), 64'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      drive(3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 19) == 0),
            -2, -1);
    end

    repeat (2) drive(3'b000, 0, 0, -1, -1);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("drain_rob_q", 64'(exp_q.size()), 64'd0);
    chk("drain_rdy_q", 64'(rdy_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
